parity_frame_receiver: RTL and testbench



---
 rtl/parity_frame_pkg.sv | 22 ++
 rtl/parity_frame_receiver.sv | 143 ++++++++++++++
 tb/tb_parity_frame_receiver.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/parity_frame_pkg.sv
// Shared types and defaults for the serial parity frame receiver.
// Frames are {parity, data} MSB first, bracketed by a start bit 0 and stop bit 1.
package parity_frame_pkg;

    localparam int DEF_DATA_W    = 4;
    localparam int DEF_ERR_CNT_W = 8;
    localparam int DEF_FRAME_W   = DEF_DATA_W + 1;

    // Bit counter must reach FRAME_W-1; keep at least one bit for tiny frames.
    function automatic int cnt_width(input int frame_w);
        return (frame_w > 1) ? $clog2(frame_w) : 1;
    endfunction

    localparam int DEF_CNT_W = cnt_width(DEF_FRAME_W);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_STOP  = 2'd2
    } state_e;

endpackage

// File: rtl/parity_frame_receiver.sv
// Deserialises start/{parity,data}/stop frames, checks even parity, holds one word for a valid/ready consumer.
// Latency: out_valid rises on the edge after the stop-bit sample; single-entry slot, a full slot drops the frame and sets sticky overflow.
module parity_frame_receiver
    import parity_frame_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int ERR_CNT_W = DEF_ERR_CNT_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 bit_en,
    input  logic                 serial_in,
    output logic [DATA_W-1:0]    out_data,
    output logic                 out_parity_err,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 framing_err,
    output logic                 overflow,
    output logic [ERR_CNT_W-1:0] err_count,
    input  logic                 clr_stats
);

    localparam int FRAME_W = DATA_W + 1;
    localparam int CNT_W   = cnt_width(FRAME_W);
    localparam logic [CNT_W-1:0]     LAST_CNT = CNT_W'(DATA_W);
    localparam logic [ERR_CNT_W-1:0] ERR_MAX  = '1;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [FRAME_W-1:0]   shift_q, shift_d;
    logic [DATA_W-1:0]    data_q, data_d;
    logic                 perr_q, perr_d;
    logic                 valid_q, valid_d;
    logic                 ferr_q, ferr_d;
    logic                 ovf_q, ovf_d;
    logic [ERR_CNT_W-1:0] err_q, err_d;

    logic frame_done;
    logic frame_bad_stop;
    logic frame_perr;
    logic slot_free;
    logic err_evt;

    always_comb begin
        frame_done     = bit_en && (state_q == ST_STOP) && serial_in;
        frame_bad_stop = bit_en && (state_q == ST_STOP) && !serial_in;
        frame_perr     = ^shift_q;
        // An accepting consumer frees the slot in the same cycle a new word lands.
        slot_free      = !valid_q || out_ready;
        err_evt        = (frame_done && frame_perr) || frame_bad_stop;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        if (bit_en) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (!serial_in) begin
                        state_d = ST_SHIFT;
                        cnt_d   = '0;
                    end
                end
                ST_SHIFT: begin
                    shift_d = {shift_q[FRAME_W-2:0], serial_in};
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_q == LAST_CNT) begin
                        state_d = ST_STOP;
                    end
                end
                ST_STOP: begin
                    // A 0 here is a bad stop bit, never a fresh start bit.
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        data_d  = data_q;
        perr_d  = perr_q;
        valid_d = valid_q;
        ovf_d   = ovf_q;
        err_d   = err_q;
        ferr_d  = frame_bad_stop;

        if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
        if (frame_done) begin
            if (slot_free) begin
                data_d  = shift_q[DATA_W-1:0];
                perr_d  = frame_perr;
                valid_d = 1'b1;
            end else begin
                ovf_d = 1'b1;
            end
        end
        if (err_evt && (err_q != ERR_MAX)) begin
            err_d = err_q + 1'b1;
        end
        if (clr_stats) begin
            ovf_d = 1'b0;
            err_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            perr_q  <= 1'b0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovf_q   <= 1'b0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            perr_q  <= perr_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovf_q   <= ovf_d;
            err_q   <= err_d;
        end
    end

    assign out_data       = data_q;
    assign out_parity_err = perr_q;
    assign out_valid      = valid_q;
    assign framing_err    = ferr_q;
    assign overflow       = ovf_q;
    assign err_count      = err_q;

endmodule

// File: tb/tb_parity_frame_receiver.sv
// Bench for parity_frame_receiver: scoreboard of delivered words plus directed statistics checks.
// A second instance with a 2-bit error counter shares all inputs to exercise saturation.
module tb_parity_frame_receiver;

    logic       clk;
    logic       rst_n;
    logic       bit_en;
    logic       serial_in;
    logic       out_ready;
    logic       clr_stats;
    logic [3:0] out_data;
    logic       out_parity_err;
    logic       out_valid;
    logic       framing_err;
    logic       overflow;
    logic [7:0] err_count;

    logic [3:0] s_out_data;
    logic       s_out_parity_err;
    logic       s_out_valid;
    logic       s_framing_err;
    logic       s_overflow;
    logic [1:0] s_err_count;

    int n_checks = 0;
    int n_fail   = 0;
    int ferr_pulses = 0;
    int exp_err8 = 0;
    int exp_err2 = 0;
    logic [4:0] sb_q[$];

    parity_frame_receiver #(.DATA_W(4), .ERR_CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .bit_en(bit_en), .serial_in(serial_in),
        .out_data(out_data), .out_parity_err(out_parity_err), .out_valid(out_valid),
        .out_ready(out_ready), .framing_err(framing_err), .overflow(overflow),
        .err_count(err_count), .clr_stats(clr_stats)
    );

    parity_frame_receiver #(.DATA_W(4), .ERR_CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .bit_en(bit_en), .serial_in(serial_in),
        .out_data(s_out_data), .out_parity_err(s_out_parity_err), .out_valid(s_out_valid),
        .out_ready(out_ready), .framing_err(s_framing_err), .overflow(s_overflow),
        .err_count(s_err_count), .clr_stats(clr_stats)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Words are popped only on a real handshake, so stalls and drops are visible as mismatches.
    always @(negedge clk) begin
        if (framing_err) ferr_pulses++;
        if (rst_n && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                chk("sb_depth", sb_q.size(), 1);
            end else begin
                logic [4:0] e;
                e = sb_q.pop_front();
                chk("sb_data", out_data, e[3:0]);
                chk("sb_perr", out_parity_err, e[4]);
                chk("sb_sat_data", s_out_data, e[3:0]);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bit_en    = 1'b0;
        serial_in = 1'b1;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send_bit(input logic b, input int period, input logic clr);
        serial_in = b;
        bit_en    = 1'b1;
        clr_stats = clr;
        tick();
        bit_en    = 1'b0;
        clr_stats = 1'b0;
        serial_in = 1'b1;
        for (int i = 1; i < period; i++) tick();
    endtask

    task automatic bump_err();
        exp_err8++;
        if (exp_err2 < 3) exp_err2++;
    endtask

    task automatic send_frame(input logic [3:0] d, input logic par, input logic stop,
                              input int period, input bit delivered, input logic clr_at_stop);
        logic perr;
        perr = par ^ (^d);
        if (delivered) sb_q.push_back({perr, d});
        send_bit(1'b0, period, 1'b0);
        send_bit(par, period, 1'b0);
        for (int i = 3; i >= 0; i--) send_bit(d[i], period, 1'b0);
        send_bit(stop, period, clr_at_stop);
    endtask

    initial begin
        int f0;
        rst_n = 1'b0; bit_en = 1'b0; serial_in = 1'b1; out_ready = 1'b1; clr_stats = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_perr", out_parity_err, 0);
        chk("rst_ferr", framing_err, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_err", err_count, 0);
        tick();
        rst_n = 1'b1;
        idle(2);

        // Good frame 1010: valid for exactly one cycle.
        send_frame(4'b1010, 1'b0, 1'b1, 1, 1, 1'b0);
        @(negedge clk);
        chk("f1_valid", out_valid, 1);
        tick();
        @(negedge clk);
        chk("f1_valid_drop", out_valid, 0);
        chk("f1_err", err_count, 0);
        tick();

        send_frame(4'b1110, 1'b1, 1'b1, 1, 1, 1'b0);
        idle(2);
        send_frame(4'b1110, 1'b0, 1'b1, 1, 1, 1'b0);
        bump_err();
        idle(2);
        @(negedge clk);
        chk("perr_err", err_count, exp_err8);

        // Bad stop bit, then idle, then a clean frame must still align.
        tick();
        f0 = ferr_pulses;
        send_frame(4'b1010, 1'b0, 1'b0, 1, 0, 1'b0);
        bump_err();
        idle(3);
        @(negedge clk);
        chk("ferr_pulses", ferr_pulses - f0, 1);
        chk("ferr_valid", out_valid, 0);
        chk("ferr_err", err_count, exp_err8);
        tick();
        send_frame(4'b1010, 1'b0, 1'b1, 1, 1, 1'b0);
        idle(2);

        // Stalled consumer: second word dropped, first held stable.
        out_ready = 1'b0;
        send_frame(4'b1010, 1'b0, 1'b1, 1, 1, 1'b0);
        idle(1);
        send_frame(4'b1110, 1'b1, 1'b1, 1, 0, 1'b0);
        idle(2);
        @(negedge clk);
        chk("ovf_flag", overflow, 1);
        chk("ovf_valid", out_valid, 1);
        chk("ovf_hold_data", out_data, 4'b1010);
        chk("ovf_pending", sb_q.size(), 1);
        tick();
        out_ready = 1'b1;
        tick();
        tick();
        @(negedge clk);
        chk("ovf_drained", out_valid, 0);
        chk("ovf_sticky", overflow, 1);
        tick();
        clr_stats = 1'b1;
        tick();
        clr_stats = 1'b0;
        exp_err8 = 0;
        exp_err2 = 0;
        @(negedge clk);
        chk("clr_ovf", overflow, 0);
        chk("clr_err", err_count, 0);

        // Slow strobe; reset lands mid-frame and discards it.
        tick();
        send_frame(4'b1110, 1'b0, 1'b1, 3, 1, 1'b0);
        bump_err();
        idle(2);
        @(negedge clk);
        chk("slow_err", err_count, exp_err8);
        tick();
        send_bit(1'b0, 3, 1'b0);
        send_bit(1'b1, 3, 1'b0);
        send_bit(1'b1, 3, 1'b0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        exp_err8 = 0;
        exp_err2 = 0;
        @(negedge clk);
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_data", out_data, 0);
        chk("mid_rst_perr", out_parity_err, 0);
        chk("mid_rst_err", err_count, 0);
        chk("mid_rst_ovf", overflow, 0);
        tick();
        idle(2);
        send_frame(4'b1110, 1'b1, 1'b1, 3, 1, 1'b0);
        idle(3);

        // Saturation of the narrow counter.
        for (int k = 0; k < 5; k++) begin
            send_frame(4'b1110, 1'b0, 1'b1, 1, 1, 1'b0);
            bump_err();
            idle(2);
        end
        @(negedge clk);
        chk("sat_err2", s_err_count, exp_err2);
        chk("sat_err8", err_count, exp_err8);
        tick();
        send_frame(4'b1110, 1'b0, 1'b1, 1, 1, 1'b1);
        exp_err8 = 0;
        exp_err2 = 0;
        idle(2);
        @(negedge clk);
        chk("clr_win_err2", s_err_count, exp_err2);
        chk("clr_win_err8", err_count, exp_err8);
        tick();
        idle(3);
        chk("sb_leftover", sb_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
